io_port_ctrl: RTL

Byte-wide I/O port controller for the accumulator processor. It runs the four-phase handshake with the input device and buffers received bytes in a small FIFO that the stage-1 controller drains. It also runs the four-phase handshake with the output device for bytes the stage-1 controller writes. Any unanswered output handshake is aborted by a timeout counter. The block sits between the processor's `input_bus`/`output_bus` pins and the stage-1 controller, and replaces direct handshake sequencing in stage 1.

---
 rtl/io_port_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
//   Byte-wide I/O port controller for the accumulator processor. It sits between
//   the processor's input_bus/output_bus pins and the stage-1 controller.
//   - Input side: four-phase handshake with the input device. Received bytes are
//     buffered in a DEPTH-entry circular FIFO. When the FIFO is full the device
//     is stalled, so no byte is ever dropped.
//   - Read port: stage 1 holds rd_req. Each pop answers with a one-cycle
//     rd_valid pulse, and rd_data holds the popped byte until the next pop.
//   - Output side: four-phase handshake with the output device. An unanswered
//     transfer is aborted after TIMEOUT cycles and flagged on out_timeout.
// Ports
//   g_clk, g_clr                  clock (rising edge); async active-low reset
//   in_dev_hs, input_bus          input device request and data
//   in_dev_ack                    input byte captured
//   rd_req, rd_data, rd_valid     stage-1 read port
//   fifo_count                    bytes buffered, 0..DEPTH
//   wr_req, wr_data, wr_busy      stage-1 write port
//   out_dev_hs, out_dev_ack       output device ready / byte taken
//   output_bus, out_strobe        output data register and request
//   out_timeout                   sticky: last output transfer aborted
module io_port_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic       in_dev_hs,
  input  logic [7:0] input_bus,
  output logic       in_dev_ack,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [3:0] fifo_count,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       wr_busy,
  input  logic       out_dev_hs,
  input  logic       out_dev_ack,
  output logic [7:0] output_bus,
  output logic       out_strobe,
  output logic       out_timeout
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);
  localparam logic [7:0]  TMO_C   = 8'(TIMEOUT);

  typedef logic [AW-1:0] ptr_t;

  typedef enum logic {
    IN_WAIT,
    IN_ACK
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_WAIT_RDY,
    O_SEND,
    O_RELEASE
  } out_state_e;

  // ---------------- input side and FIFO ----------------
  in_state_e  in_state_q, in_state_d;
  logic [7:0] mem_q [DEPTH];
  ptr_t       wptr_q, rptr_q;
  logic [3:0] count_q, count_d;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
  logic       push, pop;

  // The full test uses the registered count, so a pop in the same cycle
  // cannot open room for a push at fifo_count == DEPTH.
  assign push = (in_state_q == IN_WAIT) && in_dev_hs && (count_q < DEPTH_C);
  // The rd_valid gate limits a held rd_req to one pop every two cycles.
  assign pop  = rd_req && (count_q != '0) && !rd_valid_q;

  always_comb begin
    in_state_d = in_state_q;
    case (in_state_q)
      IN_WAIT: if (push)       in_state_d = IN_ACK;
      IN_ACK:  if (!in_dev_hs) in_state_d = IN_WAIT;
      default:                 in_state_d = IN_WAIT;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      in_state_q <= IN_WAIT;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (push) begin
        mem_q[wptr_q] <= input_bus;
        wptr_q        <= wptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_data_q <= mem_q[rptr_q];
        rptr_q    <= rptr_q + ptr_t'(1);
      end
    end
  end

  assign in_dev_ack = (in_state_q == IN_ACK);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_count = count_q;

  // ---------------- output side ----------------
  out_state_e out_state_q, out_state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] obus_q, obus_d;
  logic       tmo_q, tmo_d;

  assign cnt_inc = cnt_q + 8'd1;

  // The abort fires on the edge where the counter would reach TIMEOUT, which is
  // TIMEOUT cycles after entering O_WAIT_RDY. The counter is cleared on that
  // edge instead of holding TIMEOUT.
  always_comb begin
    out_state_d = out_state_q;
    cnt_d       = cnt_q;
    obus_d      = obus_q;
    tmo_d       = tmo_q;
    case (out_state_q)
      O_IDLE: begin
        if (wr_req) begin
          obus_d      = wr_data;
          tmo_d       = 1'b0;
          cnt_d       = '0;
          out_state_d = O_WAIT_RDY;
        end
      end
      O_WAIT_RDY: begin
        cnt_d = cnt_inc;
        if (cnt_inc == TMO_C) begin
          out_state_d = O_IDLE;
          tmo_d       = 1'b1;
          cnt_d       = '0;
        end else if (out_dev_hs) begin
          out_state_d = O_SEND;
        end
      end
      O_SEND: begin
        cnt_d = cnt_inc;
        if (cnt_inc == TMO_C) begin
          out_state_d = O_IDLE;
          tmo_d       = 1'b1;
          cnt_d       = '0;
        end else if (out_dev_ack) begin
          out_state_d = O_RELEASE;
          cnt_d       = '0;
        end
      end
      O_RELEASE: begin
        if (!out_dev_ack) out_state_d = O_IDLE;
      end
      default: out_state_d = O_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      out_state_q <= O_IDLE;
      cnt_q       <= '0;
      obus_q      <= '0;
      tmo_q       <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      cnt_q       <= cnt_d;
      obus_q      <= obus_d;
      tmo_q       <= tmo_d;
    end
  end

  assign wr_busy     = (out_state_q != O_IDLE);
  assign out_strobe  = (out_state_q == O_SEND);
  assign output_bus  = obus_q;
  assign out_timeout = tmo_q;

endmodule
